// File: rtl/vcap_line_writer_pkg.sv
// ---------------------------------------------------------------------------
// vcap_lw_pkg
// Shared types and constants for the capture line writer.
//   state_t    : line writer FSM encoding
//   FIFO_DEPTH : depth of the capture line FIFO (upper bound on pixels/line)
//   LEN_W      : width of burst length fields
//   REM_W      : width of the per-line remaining pixel counter (0..FIFO_DEPTH)
//   burst_len  : min(remaining, max_len) sized to LEN_W
// ---------------------------------------------------------------------------
package vcap_lw_pkg;

  localparam int FIFO_DEPTH = 512;
  localparam int LEN_W      = 9;
  localparam int REM_W      = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    REQ,
    DATA,
    DONE,
    WCLR
  } state_t;

  // max_len never exceeds 256, so any remaining count below it fits LEN_W bits.
  function automatic logic [LEN_W-1:0] burst_len(input logic [REM_W-1:0] remaining,
                                                 input int max_len);
    if (int'(remaining) < max_len)
      return remaining[LEN_W-1:0];
    else
      return LEN_W'(max_len);
  endfunction

endpackage

// File: rtl/vcap_line_writer_if.sv
// ---------------------------------------------------------------------------
// vcap_line_writer_if
// Burst write bus between the line writer and the SDRAM controller.
//   wr_req       : burst request (writer -> controller)
//   wr_addr      : burst start word address
//   wr_len       : words in the burst
//   wr_ack       : controller accepts the burst
//   wr_data_next : controller consumes one data word this cycle
//   wr_data      : current data word
// Modports: master = line writer, slave = SDRAM controller.
// ---------------------------------------------------------------------------
interface vcap_line_writer_if
  import vcap_lw_pkg::*;
#(
  parameter int ADDR_W = 22
) ();

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len;
  logic              wr_ack;
  logic              wr_data_next;
  logic [15:0]       wr_data;

  modport master (
    output wr_req, wr_addr, wr_len, wr_data,
    input  wr_ack, wr_data_next
  );

  modport slave (
    input  wr_req, wr_addr, wr_len, wr_data,
    output wr_ack, wr_data_next
  );

endinterface

// File: rtl/vcap_line_writer_pix_pack.sv
// ---------------------------------------------------------------------------
// vcap_pix_pack
// Combinational 12-bit {R,G,B} (4 bits each) to 16-bit word formatter.
//   pix  : in  12  {R[3:0],G[3:0],B[3:0]}
//   word : out 16  formatted word
// Build option VCAP_LW_RGB565_EN: when defined, produce RGB565 by MSB
// replication; otherwise zero-extend the RGB444 pixel.
// ---------------------------------------------------------------------------
module vcap_pix_pack (
  input  logic [11:0] pix,
  output logic [15:0] word
);

`ifdef VCAP_LW_RGB565_EN
  // Replicating the top bits into the widened fields keeps full-scale
  // white at 0xFFFF and black at 0x0000.
  assign word = {pix[11:8], pix[11], pix[7:4], pix[7:6], pix[3:0], pix[3]};
`else
  assign word = {4'h0, pix};
`endif

endmodule

// File: rtl/vcap_line_writer.sv
// ---------------------------------------------------------------------------
// vcap_line_writer
// Drains one captured line from the show-ahead line FIFO and writes it to the
// frame buffer in SDRAM as a sequence of bursts, then clears the line-ready
// flag in the capture stage. Single clock domain (RAM clock).
//
// Ports:
//   i_ram_clk      in   RAM clock
//   i_reset_n      in   asynchronous active-low reset
//   i_fifo_active  in   line-ready flag from the capture stage
//   i_fifo_line    in   line index of the buffered line
//   i_fifo_data    in   FIFO head pixel {R,G,B}
//   o_fifo_next    out  FIFO pop strobe (combinational, DATA state only)
//   o_fifo_reset   out  one-cycle clear pulse for the line-ready flag
//   i_x_size       in   capture width minus one
//   i_frame_base   in   frame-buffer base word address
//   wr             if   burst write bus (master side)
//   o_busy         out  high whenever the FSM is not IDLE
//   o_line_done    out  one-cycle pulse per completed line
//
// Build option VCAP_LW_RGB565_EN selects RGB565 output words (see
// vcap_pix_pack); timing is unaffected.
// ---------------------------------------------------------------------------
module vcap_line_writer
  import vcap_lw_pkg::*;
#(
  parameter int SCR_SIZE_BIT = 10,
  parameter int ADDR_W       = 22,
  parameter int BURST_LEN    = 8,
  parameter int LINE_STRIDE  = 1024
) (
  input  logic                  i_ram_clk,
  input  logic                  i_reset_n,
  input  logic                  i_fifo_active,
  input  logic [8:0]            i_fifo_line,
  input  logic [11:0]           i_fifo_data,
  output logic                  o_fifo_next,
  output logic                  o_fifo_reset,
  input  logic [SCR_SIZE_BIT:0] i_x_size,
  input  logic [ADDR_W-1:0]     i_frame_base,
  vcap_line_writer_if.master    wr,
  output logic                  o_busy,
  output logic                  o_line_done
);

  state_t            state;
  logic [REM_W-1:0]  remaining;
  logic [LEN_W-1:0]  beats;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              req;

  logic [SCR_SIZE_BIT+1:0] size_p1;
  logic [REM_W-1:0]        setup_rem;
  logic [ADDR_W-1:0]       line_addr;
  logic [REM_W-1:0]        rem_dec;

  // Line setup values. The pixel count is clamped to the FIFO depth so a
  // wider capture never pops past what the FIFO can hold.
  assign size_p1   = {1'b0, i_x_size} + 1'b1;
  assign setup_rem = (int'(size_p1) > FIFO_DEPTH) ? REM_W'(FIFO_DEPTH) : REM_W'(size_p1);
  assign line_addr = i_frame_base + ADDR_W'(i_fifo_line) * ADDR_W'(LINE_STRIDE);
  assign rem_dec   = remaining - REM_W'(1);

  // Pops follow the controller's consume strobe directly so the show-ahead
  // head is always the word being written.
  assign o_fifo_next = (state == DATA) && wr.wr_data_next;

  assign wr.wr_req  = req;
  assign wr.wr_addr = addr;
  assign wr.wr_len  = len;

  vcap_pix_pack u_pix_pack (
    .pix  (i_fifo_data),
    .word (wr.wr_data)
  );

  // Line writer FSM. All handshake outputs except the pop strobe are
  // registered here; a burst ends when its beat count runs out, and the line
  // ends when the remaining pixel count reaches zero at a burst boundary.
  always_ff @(posedge i_ram_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      remaining    <= '0;
      beats        <= '0;
      addr         <= '0;
      len          <= '0;
      req          <= 1'b0;
      o_fifo_reset <= 1'b0;
      o_line_done  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_fifo_active) begin
            state  <= SETUP;
            o_busy <= 1'b1;
          end
        end

        SETUP: begin
          remaining <= setup_rem;
          addr      <= line_addr;
          len       <= burst_len(setup_rem, BURST_LEN);
          req       <= 1'b1;
          state     <= REQ;
        end

        REQ: begin
          if (wr.wr_ack) begin
            req   <= 1'b0;
            beats <= len;
            state <= DATA;
          end
        end

        DATA: begin
          if (wr.wr_data_next) begin
            beats     <= beats - LEN_W'(1);
            remaining <= rem_dec;
            addr      <= addr + ADDR_W'(1);
            if (beats == LEN_W'(1)) begin
              if (rem_dec != '0) begin
                len   <= burst_len(rem_dec, BURST_LEN);
                req   <= 1'b1;
                state <= REQ;
              end else begin
                o_fifo_reset <= 1'b1;
                o_line_done  <= 1'b1;
                state        <= DONE;
              end
            end
          end
        end

        DONE: begin
          o_fifo_reset <= 1'b0;
          o_line_done  <= 1'b0;
          state        <= WCLR;
        end

        // Holding here until the flag drops keeps a flag that has not yet
        // been cleared from starting the same line a second time.
        WCLR: begin
          if (!i_fifo_active) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          req          <= 1'b0;
          o_fifo_reset <= 1'b0;
          o_line_done  <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vcap_line_writer.sv
// ---------------------------------------------------------------------------
// tb_vcap_line_writer
// Scoreboard bench for vcap_line_writer. Stimulus pushes the expected bursts,
// pixel words and line completions; a negedge monitor pops and compares them
// whenever the DUT shows a burst handshake, a FIFO pop or a line-done pulse.
// ---------------------------------------------------------------------------
module tb_vcap_line_writer;
  import vcap_lw_pkg::*;

  localparam int SCR_SIZE_BIT = 10;
  localparam int ADDR_W       = 22;
  localparam int BURST_LEN    = 8;
  localparam int LINE_STRIDE  = 1024;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [8:0]        len;
  } burst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fifo_active = 1'b0;
  logic [8:0] fifo_line = '0;
  logic [11:0] fifo_data;
  logic fifo_next;
  logic fifo_reset;
  logic [SCR_SIZE_BIT:0] x_size = '0;
  logic [ADDR_W-1:0] frame_base = '0;
  logic busy;
  logic line_done;

  vcap_line_writer_if #(.ADDR_W(ADDR_W)) wr_bus ();

  vcap_line_writer #(
    .SCR_SIZE_BIT (SCR_SIZE_BIT),
    .ADDR_W       (ADDR_W),
    .BURST_LEN    (BURST_LEN),
    .LINE_STRIDE  (LINE_STRIDE)
  ) dut (
    .i_ram_clk     (clk),
    .i_reset_n     (rst_n),
    .i_fifo_active (fifo_active),
    .i_fifo_line   (fifo_line),
    .i_fifo_data   (fifo_data),
    .o_fifo_next   (fifo_next),
    .o_fifo_reset  (fifo_reset),
    .i_x_size      (x_size),
    .i_frame_base  (frame_base),
    .wr            (wr_bus.master),
    .o_busy        (busy),
    .o_line_done   (line_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_pop_cycle = -10;
  bit mon_en = 1'b1;

  burst_t      exp_burst[$];
  logic [15:0] exp_pix[$];
  int          exp_done[$];

  // Show-ahead FIFO model: the head is pix_mem[rd_ptr], and each pop advances.
  logic [11:0] pix_mem [0:511];
  int rd_ptr = 0;
  assign fifo_data = pix_mem[rd_ptr % 512];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (fifo_next) rd_ptr <= rd_ptr + 1;
  end

  function automatic logic [15:0] fmt(input logic [11:0] p);
`ifdef VCAP_LW_RGB565_EN
    return {p[11:8], p[11], p[7:4], p[7:6], p[3:0], p[3]};
`else
    return {4'h0, p};
`endif
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push_burst(input logic [ADDR_W-1:0] a, input logic [8:0] l);
    exp_burst.push_back({a, l});
  endtask

  // Monitor: compares every observable transaction against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (wr_bus.wr_req && wr_bus.wr_ack) begin
        if (exp_burst.size() == 0) begin
          check_output("burst_unexpected", 1, 0);
        end else begin
          burst_t b;
          b = exp_burst.pop_front();
          check_output("burst_addr", 32'(wr_bus.wr_addr), 32'(b.addr));
          check_output("burst_len", 32'(wr_bus.wr_len), 32'(b.len));
        end
      end
      if (fifo_next) begin
        if (exp_pix.size() == 0) begin
          check_output("pop_unexpected", 1, 0);
        end else begin
          check_output("pop_data", 32'(wr_bus.wr_data), 32'(exp_pix.pop_front()));
        end
        last_pop_cycle = cycle;
      end
      if (line_done) begin
        check_output("done_fifo_reset", 32'(fifo_reset), 1);
        check_output("done_latency", cycle - last_pop_cycle, 1);
        check_output("done_all_pops", exp_pix.size(), 0);
        if (exp_done.size() == 0) check_output("done_unexpected", 1, 0);
        else void'(exp_done.pop_front());
      end
    end
  end

  // Plays the SDRAM controller for one line: acks each request after
  // ack_delay cycles and consumes the burst with a stall every third cycle.
  task automatic serve_line(input int ack_delay, input bit stray_next, output bit timed_out);
    int budget;
    int beats;
    int cyc;
    int ptr0;
    logic [ADDR_W-1:0] a;
    logic [8:0] l;
    budget = 4000;
    timed_out = 1'b0;
    forever begin
      while (!wr_bus.wr_req && !line_done && budget > 0) begin
        @(posedge clk); #1; budget--;
      end
      if (budget <= 0) begin
        timed_out = 1'b1;
        return;
      end
      if (line_done) return;
      a = wr_bus.wr_addr;
      l = wr_bus.wr_len;
      ptr0 = rd_ptr;
      wr_bus.wr_data_next = stray_next;
      for (int k = 0; k < ack_delay; k++) begin
        @(posedge clk); #1;
        check_output("hold_req", 32'(wr_bus.wr_req), 1);
        check_output("hold_addr", 32'(wr_bus.wr_addr), 32'(a));
        check_output("hold_len", 32'(wr_bus.wr_len), 32'(l));
        check_output("hold_no_pop", 32'(fifo_next), 0);
      end
      if (ack_delay > 0) check_output("hold_ptr", rd_ptr - ptr0, 0);
      wr_bus.wr_data_next = 1'b0;
      wr_bus.wr_ack = 1'b1;
      @(posedge clk); #1;
      wr_bus.wr_ack = 1'b0;
      check_output("req_drop", 32'(wr_bus.wr_req), 0);
      beats = 0;
      cyc = 0;
      while (beats < int'(l) && budget > 0) begin
        wr_bus.wr_data_next = (cyc % 3 != 2);
        @(posedge clk);
        if (wr_bus.wr_data_next) beats++;
        #1;
        cyc++;
        budget--;
      end
      wr_bus.wr_data_next = 1'b0;
    end
  endtask

  // Runs one complete line: loads the FIFO model, queues expected pixels and
  // completion, raises the flag, serves the bursts, then releases the flag.
  task automatic apply_stimulus(input logic [8:0] line, input logic [SCR_SIZE_BIT:0] xs,
                                input logic [ADDR_W-1:0] base, input int ack_delay,
                                input bit stray_next, input int hold_after);
    int n;
    int start_ptr;
    bit timed_out;
    logic [11:0] p;
    n = (int'(xs) + 1 > 512) ? 512 : int'(xs) + 1;
    start_ptr = rd_ptr;
    for (int i = 0; i < n; i++) begin
      p = (i == 0) ? 12'hF81 : 12'((i * 149) + (int'(line) * 7));
      pix_mem[(start_ptr + i) % 512] = p;
      exp_pix.push_back(fmt(p));
    end
    exp_done.push_back(int'(line));
    x_size = xs;
    fifo_line = line;
    frame_base = base;
    fifo_active = 1'b1;
    @(posedge clk); #1;
    check_output("setup_no_req", 32'(wr_bus.wr_req), 0);
    check_output("setup_busy", 32'(busy), 1);
    @(posedge clk); #1;
    check_output("req_latency", 32'(wr_bus.wr_req), 1);
    serve_line(ack_delay, stray_next, timed_out);
    check_output("line_complete", 32'(timed_out), 0);
    check_output("pop_count", rd_ptr - start_ptr, n);
    for (int k = 0; k < hold_after; k++) begin
      @(posedge clk); #1;
      check_output("wclr_busy", 32'(busy), 1);
      check_output("wclr_no_req", 32'(wr_bus.wr_req), 0);
    end
    fifo_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("back_to_idle", 32'(busy), 0);
  endtask

  initial begin
    wr_bus.wr_ack = 1'b0;
    wr_bus.wr_data_next = 1'b0;
    for (int i = 0; i < 512; i++) pix_mem[i] = 12'h000;
    pix_mem[0] = 12'hF81;

    // Reset state, including the combinational pixel formatter.
    #2;
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_req", 32'(wr_bus.wr_req), 0);
    check_output("rst_addr", 32'(wr_bus.wr_addr), 0);
    check_output("rst_len", 32'(wr_bus.wr_len), 0);
    check_output("rst_pop", 32'(fifo_next), 0);
    check_output("rst_fifo_reset", 32'(fifo_reset), 0);
    check_output("rst_line_done", 32'(line_done), 0);
`ifdef VCAP_LW_RGB565_EN
    check_output("pixel_f81", 32'(wr_bus.wr_data), 32'h0000FC42);
`else
    check_output("pixel_f81", 32'(wr_bus.wr_data), 32'h00000F81);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] two full bursts, line 3");
    push_burst(22'h001C00, 9'd8);
    push_burst(22'h001C08, 9'd8);
    apply_stimulus(9'd3, 11'd15, 22'h001000, 0, 1'b0, 0);

    $display("[TB] single pixel line");
    push_burst(22'h003000, 9'd1);
    apply_stimulus(9'd0, 11'd0, 22'h003000, 0, 1'b0, 0);

    $display("[TB] short final burst");
    push_burst(22'h021400, 9'd8);
    push_burst(22'h021408, 9'd8);
    push_burst(22'h021410, 9'd4);
    apply_stimulus(9'd5, 11'd19, 22'h020000, 0, 1'b0, 0);

    $display("[TB] ack held off with stray consume strobes");
    push_burst(22'h002405, 9'd8);
    push_burst(22'h00240D, 9'd1);
    apply_stimulus(9'd9, 11'd8, 22'h000005, 10, 1'b1, 0);

    $display("[TB] flag held past done, then a second line");
    push_burst(22'h000400, 9'd8);
    apply_stimulus(9'd1, 11'd7, 22'h000000, 0, 1'b0, 5);
    push_burst(22'h001000, 9'd8);
    push_burst(22'h001008, 9'd2);
    apply_stimulus(9'd4, 11'd9, 22'h000000, 0, 1'b0, 0);

    $display("[TB] reset in the middle of a burst");
    mon_en = 1'b0;
    x_size = 11'd15;
    fifo_line = 9'd7;
    frame_base = '0;
    fifo_active = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr_bus.wr_ack = 1'b1;
    @(posedge clk); #1;
    wr_bus.wr_ack = 1'b0;
    wr_bus.wr_data_next = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("abort_busy", 32'(busy), 0);
    check_output("abort_req", 32'(wr_bus.wr_req), 0);
    check_output("abort_pop", 32'(fifo_next), 0);
    check_output("abort_addr", 32'(wr_bus.wr_addr), 0);
    check_output("abort_len", 32'(wr_bus.wr_len), 0);
    check_output("abort_line_done", 32'(line_done), 0);
    wr_bus.wr_data_next = 1'b0;
    fifo_active = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    push_burst(22'h000900, 9'd4);
    apply_stimulus(9'd2, 11'd3, 22'h000100, 0, 1'b0, 0);

    $display("[TB] clamp to FIFO depth with address truncation");
    for (int k = 0; k < 64; k++) push_burst(22'h07EC00 + 22'(8 * k), 9'd8);
    apply_stimulus(9'd511, 11'd600, 22'h3FF000, 0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check_output("bursts_drained", exp_burst.size(), 0);
    check_output("pixels_drained", exp_pix.size(), 0);
    check_output("lines_drained", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
